// File: rtl/rac_pkg.sv
// Shared types and constant helpers for the round-and-clip scheduler.
package rac_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rac_state_e;

  // Width of a channel index for n requesters.
  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

  // Largest positive value of a signed final_w-bit sample.
  function automatic int max_pos(input int final_w);
    return (32'sd1 <<< (final_w - 1)) - 32'sd1;
  endfunction

  // Most negative value of a signed final_w-bit sample.
  function automatic int max_neg(input int final_w);
    return -(32'sd1 <<< (final_w - 1));
  endfunction

endpackage

// File: rtl/rac_scheduler_if.sv
// Request and output handshake bundle of the round-and-clip scheduler.
// slave = scheduler side, master = requester/downstream side.
interface rac_scheduler_if
  import rac_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 31,
  parameter int FINAL = 16
);
  localparam int IW = id_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [FINAL-1:0]       out_data;
  logic [IW-1:0]          out_id;
  logic                   out_sat;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_sat
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_sat
  );
endinterface

// File: rtl/round_and_clip.sv
// Round half up on bit SCALE-1, then clip a WIDTH-bit signed value to FINAL bits.
module round_and_clip
  import rac_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int FINAL = 16,
  parameter int SCALE = 5
) (
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [FINAL-1:0] out_data,
  output logic                    out_sat
);
  // Rounded value keeps one extra bit so the half-LSB add cannot overflow.
  localparam int RW = WIDTH + 1 - SCALE;
  localparam logic signed [RW-1:0] MAX_P = RW'(max_pos(FINAL));
  localparam logic signed [RW-1:0] MAX_N = RW'(max_neg(FINAL));

  logic signed [WIDTH:0]  sum_s;
  logic signed [RW-1:0]   rnd_s;

  // Add half an output LSB, drop the fraction bits, then saturate.
  always_comb begin
    sum_s = {in_data[WIDTH-1], in_data} + ((WIDTH+1)'(1) << (SCALE - 1));
    rnd_s = sum_s[WIDTH:SCALE];
    if (rnd_s > MAX_P) begin
      out_data = MAX_P[FINAL-1:0];
      out_sat  = 1'b1;
    end else if (rnd_s < MAX_N) begin
      out_data = MAX_N[FINAL-1:0];
      out_sat  = 1'b1;
    end else begin
      out_data = rnd_s[FINAL-1:0];
      out_sat  = 1'b0;
    end
  end
endmodule

// File: rtl/rac_scheduler.sv
// Round-robin scheduler sharing one round-and-clip datapath among N_REQ
// channels, with a single registered output slot.
// Optional feature macro: SAT_STATS_EN (per-channel saturation counters).
module rac_scheduler
  import rac_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 31,
  parameter int FINAL = 16,
  parameter int SCALE = 5,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  rac_scheduler_if.slave bus,
  output logic busy
`ifdef SAT_STATS_EN
  ,
  input  logic                     sat_clr,
  output logic [N_REQ*CNT_W-1:0]   sat_cnt
`endif
);
  localparam int IW = id_w(N_REQ);

  rac_state_e          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [FINAL-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]       out_id_q, out_id_d;
  logic                out_sat_q, out_sat_d;

  logic [IW-1:0]           grant_s;
  logic                    grant_found_s;
  logic [IW:0]             idx_s;
  logic                    accept_s;
  logic signed [WIDTH-1:0] rc_in_s;
  logic signed [FINAL-1:0] rc_data_s;
  logic                    rc_sat_s;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    idx_s         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(N_REQ)) begin
        idx_s = idx_s - (IW+1)'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!grant_found_s && bus.req_valid[idx_s[IW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_s       = idx_s[IW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Slot can take a sample when free or draining this cycle; flush and reset block grants.
  always_comb begin
    accept_s = ((state_q == EMPTY) | bus.out_ready) & ~flush & grant_found_s & ~rst;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = accept_s & (grant_s == IW'(i));
    end
  end

  // Route the granted channel's accumulator into the shared datapath.
  always_comb begin
    rc_in_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rc_in_s = (grant_s == IW'(i)) ? bus.req_data[i*WIDTH +: WIDTH] : rc_in_s;
    end
  end

  round_and_clip #(
    .WIDTH (WIDTH),
    .FINAL (FINAL),
    .SCALE (SCALE)
  ) u_rc (
    .in_data  (rc_in_s),
    .out_data (rc_data_s),
    .out_sat  (rc_sat_s)
  );

  // Slot FSM: load on accept, empty on delivery, flush overrides all.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_sat_d   = out_sat_q;
    if (flush) begin
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      rr_ptr_d    = IW'(N_REQ - 1);
    end else if (accept_s) begin
      state_d     = FULL;
      out_valid_d = 1'b1;
      out_data_d  = rc_data_s;
      out_id_d    = grant_s;
      out_sat_d   = rc_sat_s;
      rr_ptr_d    = grant_s;
    end else begin
      case (state_q)
        EMPTY: state_d = EMPTY;
        FULL: begin
          if (bus.out_ready) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Slot and arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      rr_ptr_q    <= IW'(N_REQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_sat   = out_sat_q;
  assign busy          = out_valid_q | (|bus.req_valid);

`ifdef SAT_STATS_EN
  logic [CNT_W-1:0] sat_cnt_q [N_REQ];
  logic [CNT_W-1:0] sat_cnt_d [N_REQ];

  // Count saturated slot loads per channel; clear wins, counters stick at max.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      if (sat_clr) begin
        sat_cnt_d[i] = '0;
      end else if (accept_s && rc_sat_s && (grant_s == IW'(i)) && (sat_cnt_q[i] != '1)) begin
        sat_cnt_d[i] = sat_cnt_q[i] + CNT_W'(1);
      end else begin
        sat_cnt_d[i] = sat_cnt_q[i];
      end
    end
  end

  // Saturation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) sat_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) sat_cnt_q[i] <= sat_cnt_d[i];
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) sat_cnt[i*CNT_W +: CNT_W] = sat_cnt_q[i];
  end
`endif
endmodule

// File: tb/tb_rac_scheduler.sv
// Directed self-checking bench for rac_scheduler (4 channels, 31->16 bits, 5 fraction bits).
module tb_rac_scheduler;
`ifdef SAT_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;
`ifdef SAT_STATS_EN
  logic          sat_clr = 1'b0;
  logic [4*CW-1:0] sat_cnt;
`endif

  rac_scheduler_if #(.N_REQ(4), .WIDTH(31), .FINAL(16)) bus_if ();

  rac_scheduler #(.N_REQ(4), .WIDTH(31), .FINAL(16), .SCALE(5), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_if),
    .busy  (busy)
`ifdef SAT_STATS_EN
    ,
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_req(input int ch, input logic [30:0] d);
    bus_if.req_data[ch*31 +: 31] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_if.req_valid = 4'b0001;
    bus_if.req_data  = '0;
    bus_if.out_ready = 1'b1;
    set_req(0, 31'h0000_0030);
    #2;
    n_checks++; if (bus_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0000", bus_if.req_ready); end
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus_if.out_valid); end
    n_checks++; if (bus_if.out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_out_data: got %h want 0000", bus_if.out_data); end
    n_checks++; if (bus_if.out_id !== 2'd0 || bus_if.out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_id_sat: got %0d/%b want 0/0", bus_if.out_id, bus_if.out_sat); end
    bus_if.req_valid = 4'b0000;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    set_req(0, 31'h0000_0030);
    bus_if.req_valid = 4'b0001;
    #1;
    n_checks++; if (bus_if.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", bus_if.req_ready); end
    n_checks++; if (bus_if.out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_pre: valid %b busy %b want 0/1", bus_if.out_valid, busy); end
    step();
    bus_if.req_valid = 4'b0000;
    n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h0002 || bus_if.out_id !== 2'd0 || bus_if.out_sat !== 1'b0)
      begin n_fail++; $display("FAIL single_out: got v%b d%h id%0d s%b want v1 d0002 id0 s0", bus_if.out_valid, bus_if.out_data, bus_if.out_id, bus_if.out_sat); end
    step();
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_round_robin();
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 31'((i + 1) * 32));
    bus_if.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++; if (bus_if.req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, bus_if.req_ready, 4'(1 << (c % 4))); end
      step();
      n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_id !== 2'(c % 4) || bus_if.out_data !== 16'(c % 4 + 1))
        begin n_fail++; $display("FAIL rr_out[%0d]: got v%b id%0d d%h want v1 id%0d d%h", c, bus_if.out_valid, bus_if.out_id, bus_if.out_data, c % 4, 16'(c % 4 + 1)); end
    end
    bus_if.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_rounding();
    logic [30:0] din [8]  = '{31'h0000_0030, 31'h0000_002F, 31'h7FFF_FFD0, 31'h7FFF_FFCF,
                              31'h000F_FFEF, 31'h000F_FFF0, 31'h7FF0_0000, 31'h7FEF_FFEF};
    logic [15:0] dexp [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic        sexp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus_if.req_valid = 4'b0001;
    for (int t = 0; t < 8; t++) begin
      set_req(0, din[t]);
      step();
      n_checks++; if (bus_if.out_data !== dexp[t] || bus_if.out_sat !== sexp[t] || bus_if.out_valid !== 1'b1)
        begin n_fail++; $display("FAIL round[%0d]: got d%h s%b v%b want d%h s%b v1", t, bus_if.out_data, bus_if.out_sat, bus_if.out_valid, dexp[t], sexp[t]); end
    end
    bus_if.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_saturation();
    set_req(2, 31'h0FFF_FFFF);
    bus_if.req_valid = 4'b0100;
    step();
    n_checks++; if (bus_if.out_data !== 16'h7FFF || bus_if.out_sat !== 1'b1 || bus_if.out_id !== 2'd2)
      begin n_fail++; $display("FAIL sat_pos: got d%h s%b id%0d want d7FFF s1 id2", bus_if.out_data, bus_if.out_sat, bus_if.out_id); end
    set_req(1, 31'h7000_0000);
    bus_if.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus_if.req_ready !== 4'b0010) begin n_fail++; $display("FAIL sat_b2b_ready: got %b want 0010", bus_if.req_ready); end
    step();
    n_checks++; if (bus_if.out_data !== 16'h8000 || bus_if.out_sat !== 1'b1 || bus_if.out_id !== 2'd1)
      begin n_fail++; $display("FAIL sat_neg: got d%h s%b id%0d want d8000 s1 id1", bus_if.out_data, bus_if.out_sat, bus_if.out_id); end
    bus_if.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_back_pressure();
    flush = 1'b1; step(); flush = 1'b0;
    bus_if.out_ready = 1'b0;
    set_req(1, 31'h0000_0080);
    set_req(3, 31'h0000_0060);
    bus_if.req_valid = 4'b0010;
    step();
    bus_if.req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (bus_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, bus_if.req_ready); end
      step();
      n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h0004 || bus_if.out_id !== 2'd1)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b d%h id%0d want v1 d0004 id1", c, bus_if.out_valid, bus_if.out_data, bus_if.out_id); end
    end
    bus_if.out_ready = 1'b1;
    #1;
    n_checks++; if (bus_if.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release: got %b want 1000", bus_if.req_ready); end
    step();
    n_checks++; if (bus_if.out_id !== 2'd3 || bus_if.out_data !== 16'h0003) begin n_fail++; $display("FAIL bp_ch3: got id%0d d%h want id3 d0003", bus_if.out_id, bus_if.out_data); end
    bus_if.req_valid = 4'b0010;
    step();
    n_checks++; if (bus_if.out_id !== 2'd1 || bus_if.out_data !== 16'h0004) begin n_fail++; $display("FAIL bp_ch1: got id%0d d%h want id1 d0004", bus_if.out_id, bus_if.out_data); end
    bus_if.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_flush();
    bus_if.out_ready = 1'b0;
    set_req(2, 31'h0000_0040);
    bus_if.req_valid = 4'b0100;
    step();
    set_req(0, 31'h0000_0020);
    set_req(3, 31'h0000_0060);
    bus_if.req_valid = 4'b1001;
    flush = 1'b1;
    #1;
    n_checks++; if (bus_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready: got %b want 0000", bus_if.req_ready); end
    step();
    flush = 1'b0;
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus_if.out_valid); end
    #1;
    n_checks++; if (bus_if.req_ready !== 4'b0001) begin n_fail++; $display("FAIL flush_restart: got %b want 0001", bus_if.req_ready); end
    step();
    n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_id !== 2'd0 || bus_if.out_data !== 16'h0001)
      begin n_fail++; $display("FAIL flush_ch0: got v%b id%0d d%h want v1 id0 d0001", bus_if.out_valid, bus_if.out_id, bus_if.out_data); end
    bus_if.req_valid = 4'b1000;
    bus_if.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    n_checks++; if (bus_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_rdy_both: got %b want 0000", bus_if.req_ready); end
    step();
    flush = 1'b0;
    bus_if.req_valid = 4'b0000;
    step();
    n_checks++; if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 16'h0001 || busy !== 1'b0)
      begin n_fail++; $display("FAIL idle_hold: got v%b d%h busy%b want v0 d0001 busy0", bus_if.out_valid, bus_if.out_data, busy); end
  endtask

`ifdef SAT_STATS_EN
  task automatic test_sat_stats();
    flush = 1'b1; sat_clr = 1'b1; step(); flush = 1'b0; sat_clr = 1'b0;
    n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL stats_clr0: got %h want 0", sat_cnt); end
    set_req(0, 31'h0FFF_FFFF);
    bus_if.req_valid = 4'b0001;
    bus_if.out_ready = 1'b1;
    step(); step(); step();
    n_checks++; if (sat_cnt[1:0] !== 2'd3) begin n_fail++; $display("FAIL stats_three: got %0d want 3", sat_cnt[1:0]); end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    n_checks++; if (sat_cnt[1:0] !== 2'd0) begin n_fail++; $display("FAIL stats_clear_wins: got %0d want 0", sat_cnt[1:0]); end
    step(); step();
    n_checks++; if (sat_cnt[1:0] !== 2'd2) begin n_fail++; $display("FAIL stats_two: got %0d want 2", sat_cnt[1:0]); end
    step(); step(); step();
    n_checks++; if (sat_cnt[1:0] !== 2'd3 || sat_cnt[7:2] !== 6'd0) begin n_fail++; $display("FAIL stats_stick: got %h want 3", sat_cnt); end
    bus_if.req_valid = 4'b0000;
    step();
  endtask
`endif

  task automatic test_async_reset();
    bus_if.out_ready = 1'b0;
    set_req(0, 31'h0000_0030);
    bus_if.req_valid = 4'b0001;
    step();
    bus_if.req_valid = 4'b0000;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 16'h0000) begin n_fail++; $display("FAIL async_rst: got v%b d%h want v0 d0000", bus_if.out_valid, bus_if.out_data); end
    step();
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    step();
  endtask

  initial begin
    bus_if.req_valid = 4'b0000;
    bus_if.req_data  = '0;
    bus_if.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_rounding();
    test_saturation();
    test_back_pressure();
    test_flush();
`ifdef SAT_STATS_EN
    test_sat_stats();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
